// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues reads to instruct_mem and queues
// the returned words for decode behind a valid/ready handshake.
module fetch_unit #(
  parameter int                DWIDTH   = 32,
  parameter logic [DWIDTH-1:0] RESET_PC = '0,
  parameter int                QDEPTH   = 2
) (
  input  logic              Clk_Core,
  input  logic              Rst_Core_N,
  output logic [DWIDTH-1:0] Program_Count,
  input  logic [31:0]       Instruction,
  input  logic              Redirect_Valid,
  input  logic [DWIDTH-1:0] Redirect_Pc,
  output logic              Fetch_Valid,
  output logic [31:0]       Fetch_Instr,
  output logic [DWIDTH-1:0] Fetch_Pc,
  input  logic              Fetch_Ready
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  logic [DWIDTH-1:0] fetch_pc_p0;
  logic              vld_p1;
  logic [DWIDTH-1:0] inflight_pc_p1;
  logic [31:0]       q_instr [QDEPTH];
  logic [DWIDTH-1:0] q_pc    [QDEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic [CW:0]       occupancy;
  logic              pop;
  logic              push;
  logic              issue;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign Program_Count = fetch_pc_p0;
  assign Fetch_Valid   = (count != '0);
  assign pop           = Fetch_Valid & Fetch_Ready;
  assign push          = vld_p1;
  assign occupancy     = {1'b0, count} + {{CW{1'b0}}, vld_p1};
  // A pop frees a slot at the same edge, so issue may proceed even when full.
  assign issue         = (occupancy < (CW+1)'(QDEPTH)) | pop;

  // Head is gated so idle/flushed outputs read as zero rather than stale entries.
  assign Fetch_Instr   = Fetch_Valid ? q_instr[rd_ptr] : '0;
  assign Fetch_Pc      = Fetch_Valid ? q_pc[rd_ptr]    : '0;

  // Stage p0 -> p1: PC issue, in-flight tracking and queue control
  always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
    if (!Rst_Core_N) begin
      fetch_pc_p0 <= RESET_PC;
      vld_p1      <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (Redirect_Valid) begin
      fetch_pc_p0 <= Redirect_Pc & ~DWIDTH'(3);
      vld_p1      <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      if (issue) begin
        vld_p1      <= 1'b1;
        fetch_pc_p0 <= fetch_pc_p0 + DWIDTH'(4);
      end else begin
        vld_p1      <= 1'b0;
      end
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Stage p1 -> queue: capture the memory response alongside its PC
  always_ff @(posedge Clk_Core) begin
    if (issue && !Redirect_Valid) inflight_pc_p1 <= fetch_pc_p0;
    if (push && !Redirect_Valid) begin
      q_instr[wr_ptr] <= Instruction;
      q_pc[wr_ptr]    <= inflight_pc_p1;
    end
  end

  always @(posedge Clk_Core) begin
    if (Rst_Core_N && !Redirect_Valid && push && !pop)
      assert (count != CW'(QDEPTH));
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage between instruct_mem and the core decode logic.
- Owns the program counter and drives Program_Count into instruct_mem.
- Captures the Instruction returned one cycle later into a small FIFO queue.
- Hands instructions downstream with a valid/ready handshake, and flushes and re-steers on branch/jump redirects.

Parameters:
- DWIDTH, 32, address/PC width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- QDEPTH, 2, instruction queue entries; minimum 2, which sustains 1 instr/cycle.

Ports:
- Clk_Core  in  1  core clock; all state updates on rising edge.
- Rst_Core_N  in  1  reset, asynchronous assert, active-low; clears all state.
- Program_Count  out  DWIDTH  fetch address to instruct_mem; driven directly from the fetch_pc register.
- Instruction  in  32  instruct_mem read data; corresponds to the Program_Count sampled at the previous rising edge.
- Redirect_Valid  in  1  core requests a PC change (taken branch/jump).
- Redirect_Pc  in  DWIDTH  redirect target; bits [1:0] forced to 0 internally.
- Fetch_Valid  out  1  queue head is valid.
- Fetch_Instr  out  32  queue head instruction.
- Fetch_Pc  out  DWIDTH  PC of queue head.
- Fetch_Ready  in  1  downstream accepts head this cycle.

Behaviour:
- State: fetch_pc, inflight flag, inflight_pc, QDEPTH-entry FIFO (rd/wr pointers, count 0..QDEPTH).
- Reset values: fetch_pc=RESET_PC, inflight=0, count=0. Fetch_Valid=0, Fetch_Instr=0, Fetch_Pc=0. Program_Count=RESET_PC.
- pop = Fetch_Valid & Fetch_Ready. Fetch_Valid = (count!=0). Fetch_Instr and Fetch_Pc come from the FIFO head (registered storage, no combinational path from Instruction).
- issue = (count + inflight < QDEPTH) | pop.
  - On issue at an edge: inflight_pc<=fetch_pc, inflight<=1, fetch_pc<=fetch_pc+4 (mod 2^DWIDTH; 0xFFFF_FFFC wraps to 0).
  - Otherwise: inflight<=0 and fetch_pc holds.
- push = inflight. At the edge the FIFO writes {Instruction, inflight_pc}.
  - Push and pop in the same cycle: count unchanged.
  - Push while full cannot occur by construction; assert on it.
- Redirect (highest priority), when Redirect_Valid=1 at an edge:
  - fetch_pc<=Redirect_Pc&~3, inflight<=0, count<=0, pointers reset.
  - No push and no issue in that cycle; the in-flight response is squashed.
  - A pop coinciding with the redirect counts as accepted by downstream.
- Latency:
  - Redirect edge R: Program_Count=target after R; fetch issued at R+1; Fetch_Valid=1 with Fetch_Pc=target after R+2.
  - After reset release: RESET_PC issued at first edge E1; Fetch_Valid=1 after E2.
- Throughput: with Fetch_Ready held 1, one instruction per cycle, sequential PCs +4.
- Backpressure:
  - While Fetch_Valid & !Fetch_Ready, Fetch_Instr and Fetch_Pc stay stable.
  - Fetching continues until count+inflight=QDEPTH, then fetch_pc holds.
  - No instruction is lost or duplicated.
- Program_Count changes only at edges (glitch-free register output).
- Asynchronous reset mid-operation: all state clears immediately; the queue and in-flight fetch are discarded.

Test Plan:
- Reset release, RESET_PC=0, Fetch_Ready=1, memory word[n]=n -> Fetch_Valid rises after 2nd edge. Fetch_Pc sequence 0,4,8,12… with Fetch_Instr 0,1,2,3…, one per cycle.
- Fetch_Ready=0 for 5 cycles after first valid -> head stays PC 0. Program_Count stalls at 8 (queue holds 0,4). On release, PCs 0,4,8 delivered in consecutive cycles with no gap or duplicate.
- Redirect_Valid=1, Redirect_Pc=0x100 while queue holds 0x10,0x14 -> queue flushed, Fetch_Valid=0 for 2 cycles, next Fetch_Pc=0x100.
- Redirect_Pc=0x103 -> fetches 0x100; Redirect coincident with pop -> pop accepted, no stale PC emitted afterward.
- RESET_PC=32'hFFFF_FFF8 -> Fetch_Pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Rst_Core_N asserted mid-stream with queue full -> Fetch_Valid=0 immediately. After release, fetch restarts at RESET_PC.
